// File: rtl/rsa_req_arbiter_pkg.sv
// Shared definitions for the rsa_rfid request arbiter: FSM encoding, default widths, clog2 helper.
package rsa_arb_pkg;

  localparam int unsigned DEFAULT_WORD_SIZE = 32;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (((value - 1) >> i) != 0) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rsa_req_arbiter_if.sv
// Requester and engine side signals of the rsa_rfid arbiter; master = arbiter view, slave = environment view.
interface rsa_req_arbiter_if #(
  parameter int unsigned WordSize = rsa_arb_pkg::DEFAULT_WORD_SIZE,
  parameter int unsigned NumReq   = 4
);

  logic [NumReq-1:0]          req;
  logic [NumReq*WordSize-1:0] req_text;
  logic [NumReq*WordSize-1:0] req_key;
  logic [NumReq*WordSize-1:0] req_mod;
  logic [NumReq-1:0]          gnt;
  logic [NumReq-1:0]          rsp_valid;
  logic [WordSize-1:0]        rsp_text;
  logic                       rsp_err;
  logic                       busy;
  logic [WordSize-1:0]        eng_text;
  logic [WordSize-1:0]        eng_key;
  logic [WordSize-1:0]        eng_mod;
  logic                       eng_go;
  logic                       eng_done;
  logic [WordSize-1:0]        eng_result;

  modport master (
    input  req, req_text, req_key, req_mod, eng_done, eng_result,
    output gnt, rsp_valid, rsp_text, rsp_err, busy,
           eng_text, eng_key, eng_mod, eng_go
  );

  modport slave (
    output req, req_text, req_key, req_mod, eng_done, eng_result,
    input  gnt, rsp_valid, rsp_text, rsp_err, busy,
           eng_text, eng_key, eng_mod, eng_go
  );

endinterface

// File: rtl/rsa_req_arbiter_rr_picker.sv
// Combinational round-robin search: first asserted req at or above rr_ptr, wrapping modulo NumReq.
module rr_picker
  import rsa_arb_pkg::*;
#(
  parameter  int unsigned NumReq = 4,
  localparam int unsigned IdxW   = clog2(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   rr_ptr,
  output logic              any,
  output logic [IdxW-1:0]   winner
);

  int idx;

  // Scan from the farthest offset down so the nearest request is written last and wins.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = int'(NumReq) - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= int'(NumReq)) idx = idx - int'(NumReq);
      if (req[IdxW'(idx)]) begin
        any    = 1'b1;
        winner = IdxW'(idx);
      end
    end
  end

endmodule

// File: rtl/rsa_req_arbiter.sv
// Round-robin sequencer sharing one rsa_rfid modexp engine between NumReq requesters, with a hang watchdog.
module rsa_req_arbiter
  import rsa_arb_pkg::*;
#(
  parameter int unsigned WordSize      = DEFAULT_WORD_SIZE,
  parameter int unsigned NumReq        = 4,
  parameter int unsigned TimeoutCycles = 4096
) (
  input  logic               clk,
  input  logic               reset,
  rsa_req_arbiter_if.master  bus
);

  localparam int unsigned IdxW = clog2(NumReq);
  localparam int unsigned WdW  = clog2(TimeoutCycles);

  logic [2:0]          state, state_nxt;
  logic [IdxW-1:0]     winner, winner_nxt;
  logic [IdxW-1:0]     rr_ptr, rr_ptr_nxt;
  logic [WdW-1:0]      watchdog, wd_nxt;
  logic [WordSize-1:0] eng_text_q, eng_text_nxt;
  logic [WordSize-1:0] eng_key_q, eng_key_nxt;
  logic [WordSize-1:0] eng_mod_q, eng_mod_nxt;
  logic [WordSize-1:0] rsp_text_q, rsp_text_nxt;
  logic [NumReq-1:0]   gnt_q, gnt_nxt;
  logic [NumReq-1:0]   rsp_valid_q, rsp_valid_nxt;
  logic                rsp_err_q, rsp_err_nxt;
  logic                eng_go_q, eng_go_nxt;
  logic                busy_q, busy_nxt;
  logic                pick_any;
  logic [IdxW-1:0]     pick_idx;

  rr_picker #(.NumReq(NumReq)) u_picker (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .any    (pick_any),
    .winner (pick_idx)
  );

  // State and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      winner      <= '0;
      rr_ptr      <= '0;
      watchdog    <= '0;
      eng_text_q  <= '0;
      eng_key_q   <= '0;
      eng_mod_q   <= '0;
      rsp_text_q  <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      eng_go_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      winner      <= winner_nxt;
      rr_ptr      <= rr_ptr_nxt;
      watchdog    <= wd_nxt;
      eng_text_q  <= eng_text_nxt;
      eng_key_q   <= eng_key_nxt;
      eng_mod_q   <= eng_mod_nxt;
      rsp_text_q  <= rsp_text_nxt;
      gnt_q       <= gnt_nxt;
      rsp_valid_q <= rsp_valid_nxt;
      rsp_err_q   <= rsp_err_nxt;
      eng_go_q    <= eng_go_nxt;
      busy_q      <= busy_nxt;
    end
  end

  // Next state and next registered outputs; pulses default low, data holds.
  always_comb begin
    state_nxt     = state;
    winner_nxt    = winner;
    rr_ptr_nxt    = rr_ptr;
    wd_nxt        = watchdog;
    eng_text_nxt  = eng_text_q;
    eng_key_nxt   = eng_key_q;
    eng_mod_nxt   = eng_mod_q;
    rsp_text_nxt  = rsp_text_q;
    rsp_err_nxt   = rsp_err_q;
    gnt_nxt       = '0;
    rsp_valid_nxt = '0;
    eng_go_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt    = LOAD;
          winner_nxt   = pick_idx;
          eng_text_nxt = bus.req_text[int'(pick_idx)*int'(WordSize) +: WordSize];
          eng_key_nxt  = bus.req_key[int'(pick_idx)*int'(WordSize) +: WordSize];
          eng_mod_nxt  = bus.req_mod[int'(pick_idx)*int'(WordSize) +: WordSize];
          gnt_nxt      = NumReq'(1) << pick_idx;
        end
      end
      LOAD: begin
        state_nxt  = START;
        eng_go_nxt = 1'b1;
        wd_nxt     = '0;
        rr_ptr_nxt = (int'(winner) == int'(NumReq) - 1) ? '0 : winner + IdxW'(1);
      end
      START: begin
        state_nxt = WAIT;
        wd_nxt    = '0;
      end
      WAIT: begin
        if (watchdog != '1) wd_nxt = watchdog + WdW'(1);
        // Completion takes priority over a coincident timeout.
        if (bus.eng_done) begin
          state_nxt     = RESP;
          rsp_text_nxt  = bus.eng_result;
          rsp_err_nxt   = 1'b0;
          rsp_valid_nxt = NumReq'(1) << winner;
        end else if (watchdog == WdW'(TimeoutCycles - 1)) begin
          state_nxt     = RESP;
          rsp_text_nxt  = '0;
          rsp_err_nxt   = 1'b1;
          rsp_valid_nxt = NumReq'(1) << winner;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_text  = rsp_text_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = busy_q;
  assign bus.eng_text  = eng_text_q;
  assign bus.eng_key   = eng_key_q;
  assign bus.eng_mod   = eng_mod_q;
  assign bus.eng_go    = eng_go_q;

endmodule

// File: tb/tb_rsa_req_arbiter.sv
// Directed bench: arbiter A with a behavioural modexp engine, arbiter B (TimeoutCycles=16) with a dead engine.
module tb_rsa_req_arbiter;

  localparam int unsigned W = 32;
  localparam int unsigned N = 4;

  logic clk;
  logic reset;
  logic eng_clr;
  int   eng_lat;
  int   eng_cnt;
  logic eng_active;
  logic [W-1:0] eng_res_q;
  int   n_checks;
  int   n_fail;

  rsa_req_arbiter_if #(.WordSize(W), .NumReq(N)) a_if ();
  rsa_req_arbiter_if #(.WordSize(W), .NumReq(N)) b_if ();

  rsa_req_arbiter #(.WordSize(W), .NumReq(N), .TimeoutCycles(4096)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (a_if.master)
  );

  rsa_req_arbiter #(.WordSize(W), .NumReq(N), .TimeoutCycles(16)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1, "global timeout");
  end

  function automatic logic [W-1:0] modexp(input logic [W-1:0] t, input logic [W-1:0] k,
                                          input logic [W-1:0] m);
    longint unsigned r, b;
    r = 1;
    b = longint'(t) % longint'(m);
    for (int i = 0; i < int'(W); i++) begin
      if (k[i]) r = (r * b) % longint'(m);
      b = (b * b) % longint'(m);
    end
    return W'(r);
  endfunction

  // Engine model: done rises eng_lat cycles after go and stays high until the next go.
  always @(posedge clk) begin
    if (eng_clr) begin
      a_if.eng_done   <= 1'b0;
      a_if.eng_result <= '0;
      eng_active      <= 1'b0;
      eng_cnt         <= 0;
      eng_res_q       <= '0;
    end else if (a_if.eng_go) begin
      a_if.eng_done <= 1'b0;
      eng_active    <= 1'b1;
      eng_cnt       <= eng_lat - 1;
      eng_res_q     <= modexp(a_if.eng_text, a_if.eng_key, a_if.eng_mod);
    end else if (eng_active) begin
      if (eng_cnt == 1) begin
        a_if.eng_done   <= 1'b1;
        a_if.eng_result <= eng_res_q;
        eng_active      <= 1'b0;
      end else begin
        eng_cnt <= eng_cnt - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic a_cond(input int which);
    case (which)
      0:       return |a_if.gnt;
      1:       return a_if.eng_go;
      default: return |a_if.rsp_valid;
    endcase
  endfunction

  task automatic wait_a(input int which, input int bound, output int n);
    n = 0;
    while (!a_cond(which) && n < bound) begin
      step();
      n++;
    end
    if (!a_cond(which)) check($sformatf("wait_a%0d_timeout", which), 64'(a_cond(which)), 64'd1);
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] t, input logic [W-1:0] k,
                         input logic [W-1:0] m);
    a_if.req_text[i*int'(W) +: W] = t;
    a_if.req_key[i*int'(W) +: W]  = k;
    a_if.req_mod[i*int'(W) +: W]  = m;
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_gnt"},       64'(a_if.gnt),       64'd0);
    check({pfx, "_rsp_valid"}, 64'(a_if.rsp_valid), 64'd0);
    check({pfx, "_busy"},      64'(a_if.busy),      64'd0);
    check({pfx, "_eng_go"},    64'(a_if.eng_go),    64'd0);
    check({pfx, "_eng_text"},  64'(a_if.eng_text),  64'd0);
    check({pfx, "_eng_key"},   64'(a_if.eng_key),   64'd0);
    check({pfx, "_eng_mod"},   64'(a_if.eng_mod),   64'd0);
    check({pfx, "_rsp_text"},  64'(a_if.rsp_text),  64'd0);
    check({pfx, "_rsp_err"},   64'(a_if.rsp_err),   64'd0);
  endtask

  int exp_g [5] = '{0, 1, 2, 3, 0};
  int exp_r [5] = '{4, 9, 16, 25, 4};

  initial begin
    int n;
    int spurious;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    eng_clr  = 1'b1;
    eng_lat  = 40;
    a_if.req = '0;
    a_if.req_text = '0;
    a_if.req_key  = '0;
    a_if.req_mod  = '0;
    b_if.req = '0;
    b_if.req_text = '0;
    b_if.req_key  = '0;
    b_if.req_mod  = '0;
    b_if.eng_done   = 1'b0;
    b_if.eng_result = 32'hDEAD_BEEF;
    step();
    step();
    reset   = 1'b0;
    eng_clr = 1'b0;

    check_idle_outputs("reset");
    check("reset_b_busy", 64'(b_if.busy), 64'd0);

    // Test 1: single request, result 5^3 mod 33 = 26, gnt at +1, go at +2, rsp 41 cycles after go.
    set_ops(2, 32'd5, 32'd3, 32'd33);
    a_if.req = 4'b0100;
    step();
    check("t1_gnt",      64'(a_if.gnt),      64'h4);
    check("t1_busy",     64'(a_if.busy),     64'd1);
    check("t1_eng_text", 64'(a_if.eng_text), 64'd5);
    check("t1_eng_key",  64'(a_if.eng_key),  64'd3);
    check("t1_eng_mod",  64'(a_if.eng_mod),  64'd33);
    a_if.req = '0;
    step();
    check("t1_go",       64'(a_if.eng_go),   64'd1);
    check("t1_gnt_pulse", 64'(a_if.gnt),     64'd0);
    wait_a(2, 100, n);
    check("t1_rsp_lat",   64'(n),              64'd41);
    check("t1_rsp_valid", 64'(a_if.rsp_valid), 64'h4);
    check("t1_rsp_text",  64'(a_if.rsp_text),  64'd26);
    check("t1_rsp_err",   64'(a_if.rsp_err),   64'd0);
    check("t1_eng_stable", 64'(a_if.eng_text), 64'd5);
    step();
    check("t1_rsp_pulse", 64'(a_if.rsp_valid), 64'd0);
    check("t1_idle_busy", 64'(a_if.busy),      64'd0);

    // Test 6: stale done from job 1 is still high; 4^2 mod 7 = 2 must come from the new job.
    set_ops(1, 32'd4, 32'd2, 32'd7);
    a_if.req = 4'b0010;
    step();
    check("t6_gnt", 64'(a_if.gnt), 64'h2);
    a_if.req = '0;
    step();
    check("t6_go", 64'(a_if.eng_go), 64'd1);
    wait_a(2, 100, n);
    check("t6_rsp_lat",   64'(n),              64'd41);
    check("t6_rsp_valid", 64'(a_if.rsp_valid), 64'h2);
    check("t6_rsp_text",  64'(a_if.rsp_text),  64'd2);

    // Test 2: all requesting from rr_ptr=0 -> 0,1,2,3,0; results (i+2)^2 mod 100.
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t2_reset_busy", 64'(a_if.busy), 64'd0);
    eng_lat = 5;
    for (int i = 0; i < int'(N); i++) set_ops(i, W'(i + 2), 32'd2, 32'd100);
    a_if.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_a(0, 50, n);
      check($sformatf("t2_gnt%0d", k), 64'(a_if.gnt), 64'd1 << exp_g[k]);
      wait_a(2, 50, n);
      check($sformatf("t2_rsp_valid%0d", k), 64'(a_if.rsp_valid), 64'd1 << exp_g[k]);
      check($sformatf("t2_rsp_text%0d", k),  64'(a_if.rsp_text),  64'(exp_r[k]));
    end
    a_if.req = '0;
    step();

    // Test 3: req[3] then req[0]|req[3]; rr_ptr must wrap 3 -> 0 so requester 0 wins.
    a_if.req = 4'b1000;
    wait_a(0, 50, n);
    check("t3_gnt3", 64'(a_if.gnt), 64'h8);
    a_if.req = '0;
    wait_a(2, 50, n);
    check("t3_rsp_text3", 64'(a_if.rsp_text), 64'd25);
    a_if.req = 4'b1001;
    wait_a(0, 50, n);
    check("t3_gnt0", 64'(a_if.gnt), 64'h1);
    a_if.req = '0;
    wait_a(2, 50, n);
    check("t3_rsp_valid0", 64'(a_if.rsp_valid), 64'h1);
    check("t3_rsp_text0",  64'(a_if.rsp_text),  64'd4);
    step();

    // Test 5: reset while in WAIT abandons the job; later done is ignored; next job served.
    eng_lat  = 40;
    a_if.req = 4'b0001;
    wait_a(0, 50, n);
    a_if.req = '0;
    wait_a(1, 10, n);
    for (int i = 0; i < 5; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle_outputs("t5");
    spurious = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (a_if.rsp_valid != '0 || a_if.busy) spurious++;
    end
    check("t5_no_rsp", 64'(spurious), 64'd0);
    a_if.req = 4'b0100;
    wait_a(0, 50, n);
    check("t5_gnt", 64'(a_if.gnt), 64'h4);
    a_if.req = '0;
    wait_a(2, 100, n);
    check("t5_rsp_valid", 64'(a_if.rsp_valid), 64'h4);
    check("t5_rsp_text",  64'(a_if.rsp_text),  64'd16);

    // Test 4: dead engine on B -> abort 16 cycles after WAIT entry (17 after go).
    b_if.req_text[1*int'(W) +: W] = 32'd7;
    b_if.req_key[1*int'(W) +: W]  = 32'd3;
    b_if.req_mod[1*int'(W) +: W]  = 32'd11;
    b_if.req = 4'b0010;
    n = 0;
    while (b_if.gnt == '0 && n < 20) begin
      step();
      n++;
    end
    check("t4_gnt", 64'(b_if.gnt), 64'h2);
    b_if.req = '0;
    step();
    check("t4_go", 64'(b_if.eng_go), 64'd1);
    n = 0;
    while (b_if.rsp_valid == '0 && n < 100) begin
      step();
      n++;
    end
    check("t4_rsp_lat",   64'(n),              64'd17);
    check("t4_rsp_valid", 64'(b_if.rsp_valid), 64'h2);
    check("t4_rsp_err",   64'(b_if.rsp_err),   64'd1);
    check("t4_rsp_text",  64'(b_if.rsp_text),  64'd0);
    step();
    check("t4_idle_busy", 64'(b_if.busy),      64'd0);
    check("t4_rsp_pulse", 64'(b_if.rsp_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
